// File: rtl/bus_tx_scheduler_if.sv
// Handshake and bus signals between the transmit scheduler, its two
// requesters and the tx/rx control modules.
interface bus_tx_scheduler_if;
    logic        BPS_CLK;
    logic        Rx_Pin_In;
    logic        Rx_Busy;
    logic        Req0;
    logic        Req1;
    logic [31:0] Data0;
    logic [31:0] Data1;
    logic        Ack0;
    logic        Ack1;
    logic        Fail0;
    logic        Fail1;
    logic        Tx_En_Sig;
    logic [31:0] Tx_Data;
    logic        Tx_Done_Sig;
    logic        Tx_Cancel;
    logic        Busy;

    // Scheduler side
    modport master (
        input  BPS_CLK, Rx_Pin_In, Rx_Busy, Req0, Req1, Data0, Data1,
               Tx_Done_Sig, Tx_Cancel,
        output Ack0, Ack1, Fail0, Fail1, Tx_En_Sig, Tx_Data, Busy
    );

    // Requester / tx-rx control side
    modport slave (
        output BPS_CLK, Rx_Pin_In, Rx_Busy, Req0, Req1, Data0, Data1,
               Tx_Done_Sig, Tx_Cancel,
        input  Ack0, Ack1, Fail0, Fail1, Tx_En_Sig, Tx_Data, Busy
    );
endinterface

// File: rtl/bus_tx_scheduler.sv
// Transmit scheduler for a shared single-wire bus: round-robin between two
// requesters, waits for a quiet-bus window, backs off and retries on
// collision, and reports success or failure per request.
module bus_tx_scheduler #(
    parameter int IDLE_BITS    = 8,
    parameter int BACKOFF_BASE = 4,
    parameter int MAX_RETRY    = 3
) (
    input logic                CLK,
    input logic                RST,
    bus_tx_scheduler_if.master bus
);
    localparam int AW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE, ARB, WAIT_IDLE, TX, BACKOFF, RESULT
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;
    logic [7:0]    bo_cnt_q, bo_cnt_d;
    logic [AW-1:0] att_q, att_d;
    logic [AW-1:0] att_inc;
    logic          gid_q, gid_d;
    logic          last_q, last_d;
    logic          ok_q, ok_d;
    logic [31:0]   data_q, data_d;
    logic          grant;

    // State and counter registers; reset returns everything to the idle view
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            bo_cnt_q   <= '0;
            att_q      <= '0;
            gid_q      <= 1'b0;
            last_q     <= 1'b1;
            ok_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            bo_cnt_q   <= bo_cnt_d;
            att_q      <= att_d;
            gid_q      <= gid_d;
            last_q     <= last_d;
            ok_q       <= ok_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic: arbitration, quiet-window count, collision backoff
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        bo_cnt_d   = bo_cnt_q;
        att_d      = att_q;
        gid_d      = gid_q;
        last_d     = last_q;
        ok_d       = ok_q;
        data_d     = data_q;
        att_inc    = att_q + 1'b1;
        // On a tie the requester that did not win last time gets the bus
        grant      = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;

        case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) state_d = ARB;
            end
            ARB: begin
                if (!bus.Req0 && !bus.Req1) begin
                    state_d = IDLE;
                end else begin
                    gid_d      = grant;
                    last_d     = grant;
                    data_d     = grant ? bus.Data1 : bus.Data0;
                    att_d      = '0;
                    idle_cnt_d = '0;
                    state_d    = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (bus.BPS_CLK) begin
                    if (bus.Rx_Pin_In && !bus.Rx_Busy) begin
                        if (idle_cnt_q == 8'(IDLE_BITS - 1)) begin
                            idle_cnt_d = '0;
                            state_d    = TX;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 8'd1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
            end
            TX: begin
                // A collision outranks a simultaneous completion
                if (bus.Tx_Cancel) begin
                    att_d = att_inc;
                    if (att_inc == AW'(MAX_RETRY)) begin
                        ok_d    = 1'b0;
                        state_d = RESULT;
                    end else begin
                        // gid offset keeps the two local requesters apart
                        bo_cnt_d = 8'(BACKOFF_BASE * int'(att_inc) + int'(gid_q));
                        state_d  = BACKOFF;
                    end
                end else if (bus.Tx_Done_Sig) begin
                    ok_d    = 1'b1;
                    state_d = RESULT;
                end
            end
            BACKOFF: begin
                if (bus.BPS_CLK) begin
                    bo_cnt_d = bo_cnt_q - 8'd1;
                    if (bo_cnt_q <= 8'd1) begin
                        bo_cnt_d   = '0;
                        idle_cnt_d = '0;
                        state_d    = WAIT_IDLE;
                    end
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Tx_En_Sig = (state_q == TX);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Tx_Data   = data_q;
    assign bus.Ack0      = (state_q == RESULT) &&  ok_q && !gid_q;
    assign bus.Ack1      = (state_q == RESULT) &&  ok_q &&  gid_q;
    assign bus.Fail0     = (state_q == RESULT) && !ok_q && !gid_q;
    assign bus.Fail1     = (state_q == RESULT) && !ok_q &&  gid_q;
endmodule

// File: tb/tb_bus_tx_scheduler.sv
// Scoreboard bench for bus_tx_scheduler.
module tb_bus_tx_scheduler;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit          gid;
        bit          ok;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    bus_tx_scheduler_if bus ();

    bus_tx_scheduler #(.IDLE_BITS(8), .BACKOFF_BASE(4), .MAX_RETRY(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick(input bit pin, input bit rbusy);
        bus.BPS_CLK   = 1'b1;
        bus.Rx_Pin_In = pin;
        bus.Rx_Busy   = rbusy;
        cyc();
        bus.BPS_CLK   = 1'b0;
        bus.Rx_Pin_In = 1'b1;
        bus.Rx_Busy   = 1'b0;
        cyc();
    endtask

    // n-1 full ticks with Tx_En still low, then the n-th tick raises it
    task automatic ticks_then_tx(input string tag, input int n);
        for (int i = 0; i < n - 1; i++) tick(1'b1, 1'b0);
        chk({tag, "_en_early"}, bus.Tx_En_Sig, 0);
        bus.BPS_CLK = 1'b1;
        cyc();
        bus.BPS_CLK = 1'b0;
        chk({tag, "_en"}, bus.Tx_En_Sig, 1);
    endtask

    task automatic start_req(input bit r0, input bit r1);
        bus.Req0 = r0;
        bus.Req1 = r1;
        cyc();
        cyc();
        chk("busy_wait", bus.Busy, 1);
    endtask

    task automatic finish_done(input string tag);
        bus.Tx_Done_Sig = 1'b1;
        cyc();
        bus.Tx_Done_Sig = 1'b0;
        chk({tag, "_en_off"}, bus.Tx_En_Sig, 0);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        cyc();
        chk({tag, "_idle"}, bus.Busy, 0);
    endtask

    task automatic collide(input string tag, input bit with_done);
        bus.Tx_Cancel   = 1'b1;
        bus.Tx_Done_Sig = with_done;
        cyc();
        bus.Tx_Cancel   = 1'b0;
        bus.Tx_Done_Sig = 1'b0;
        chk({tag, "_en_drop"}, bus.Tx_En_Sig, 0);
    endtask

    // Result monitor: every Ack/Fail pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (!RST && (bus.Ack0 || bus.Ack1 || bus.Fail0 || bus.Fail1)) begin
            if (sb.size() == 0) begin
                chk("unexp_result", {bus.Ack0, bus.Ack1, bus.Fail0, bus.Fail1}, 0);
            end else begin
                exp_t e;
                logic [3:0] code;
                e = sb.pop_front();
                code = e.ok ? (e.gid ? 4'b0100 : 4'b1000)
                            : (e.gid ? 4'b0001 : 4'b0010);
                chk("result", {bus.Ack0, bus.Ack1, bus.Fail0, bus.Fail1}, code);
                chk("result_data", bus.Tx_Data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.BPS_CLK = 0; bus.Rx_Pin_In = 1; bus.Rx_Busy = 0;
        bus.Req0 = 0; bus.Req1 = 0; bus.Data0 = 0; bus.Data1 = 0;
        bus.Tx_Done_Sig = 0; bus.Tx_Cancel = 0;
        cyc();
        cyc();
        chk("rst_busy", bus.Busy, 0);
        chk("rst_en", bus.Tx_En_Sig, 0);
        chk("rst_data", bus.Tx_Data, 0);
        chk("rst_res", {bus.Ack0, bus.Ack1, bus.Fail0, bus.Fail1}, 0);
        RST = 1'b0;
        cyc();

        // Single requester on a quiet bus
        bus.Data0 = 32'hA5A5_1234;
        sb.push_back('{gid: 1'b0, ok: 1'b1, data: 32'hA5A5_1234});
        start_req(1'b1, 1'b0);
        ticks_then_tx("single", 8);
        chk("single_data", bus.Tx_Data, 32'hA5A5_1234);
        finish_done("single");

        // Tie after reset: 0 first, then 1, then a new tie goes to 0
        RST = 1'b1; cyc(); RST = 1'b0; cyc();
        bus.Data0 = 32'h0000_D000;
        bus.Data1 = 32'h1111_D111;
        sb.push_back('{gid: 1'b0, ok: 1'b1, data: 32'h0000_D000});
        sb.push_back('{gid: 1'b1, ok: 1'b1, data: 32'h1111_D111});
        start_req(1'b1, 1'b1);
        ticks_then_tx("tie_a", 8);
        chk("tie_a_data", bus.Tx_Data, 32'h0000_D000);
        bus.Tx_Done_Sig = 1'b1; cyc(); bus.Tx_Done_Sig = 1'b0;
        bus.Req0 = 1'b0;
        cyc();
        cyc();
        cyc();
        ticks_then_tx("tie_b", 8);
        chk("tie_b_data", bus.Tx_Data, 32'h1111_D111);
        finish_done("tie_b");
        sb.push_back('{gid: 1'b0, ok: 1'b1, data: 32'h0000_D000});
        start_req(1'b1, 1'b1);
        ticks_then_tx("tie_c", 8);
        chk("tie_c_data", bus.Tx_Data, 32'h0000_D000);
        finish_done("tie_c");

        // Bus activity mid-window restarts the idle count
        bus.Data0 = 32'hCAFE_0003;
        sb.push_back('{gid: 1'b0, ok: 1'b1, data: 32'hCAFE_0003});
        start_req(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        ticks_then_tx("pinlow", 8);
        finish_done("pinlow");

        // Receiver busy mid-window also restarts it
        sb.push_back('{gid: 1'b0, ok: 1'b1, data: 32'hCAFE_0003});
        start_req(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        ticks_then_tx("rxbusy", 8);
        finish_done("rxbusy");

        // Requester 1 collides once: backoff 5 then 8 idle ticks
        bus.Data1 = 32'h0BAD_F00D;
        sb.push_back('{gid: 1'b1, ok: 1'b1, data: 32'h0BAD_F00D});
        start_req(1'b0, 1'b1);
        ticks_then_tx("r1_first", 8);
        collide("r1_c1", 1'b0);
        chk("r1_bo_busy", bus.Busy, 1);
        ticks_then_tx("r1_retry", 13);
        finish_done("r1");

        // Requester 0 collides three times: backoffs 4 and 8, then Fail0
        bus.Data0 = 32'h7777_0000;
        sb.push_back('{gid: 1'b0, ok: 1'b0, data: 32'h7777_0000});
        start_req(1'b1, 1'b0);
        ticks_then_tx("r0_a1", 8);
        collide("r0_c1", 1'b0);
        ticks_then_tx("r0_a2", 12);
        collide("r0_c2", 1'b0);
        ticks_then_tx("r0_a3", 16);
        bus.Tx_Cancel = 1'b1; cyc(); bus.Tx_Cancel = 1'b0;
        chk("r0_fail", {bus.Ack0, bus.Fail0}, 2'b01);
        bus.Req0 = 1'b0;
        cyc();
        chk("r0_fail_idle", bus.Busy, 0);

        // Cancel with done in the same cycle counts as a collision
        bus.Data1 = 32'h5555_AAAA;
        sb.push_back('{gid: 1'b1, ok: 1'b1, data: 32'h5555_AAAA});
        start_req(1'b0, 1'b1);
        ticks_then_tx("both_a1", 8);
        collide("both_c1", 1'b1);
        chk("both_no_ack", {bus.Ack1, bus.Fail1}, 2'b00);
        chk("both_busy", bus.Busy, 1);
        ticks_then_tx("both_a2", 13);
        finish_done("both");

        // Reset during TX: everything drops, no result pulse
        bus.Data0 = 32'hDEAD_BEEF;
        start_req(1'b1, 1'b0);
        ticks_then_tx("rst_tx", 8);
        RST = 1'b1;
        cyc();
        chk("rsttx_en", bus.Tx_En_Sig, 0);
        chk("rsttx_busy", bus.Busy, 0);
        chk("rsttx_data", bus.Tx_Data, 0);
        chk("rsttx_res", {bus.Ack0, bus.Ack1, bus.Fail0, bus.Fail1}, 0);
        bus.Req0 = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("rsttx_idle", bus.Busy, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
